// File: rtl/uart_rx_frame.sv
// RS232 receiver: 2-flop input sync, 3-sample mid-bit majority, start-glitch rejection,
// and a valid/ready output register with parity, framing and overrun reporting.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o,
  output logic [2:0]           state_o
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_S0  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1  = CW'(HALF);
  localparam logic [CW-1:0] CNT_MID = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q, sync2_q, rx_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_pend_q, perr_pend_d;
  logic                 ferr_pend_q, ferr_pend_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic rx_s, maj, mid, bit_end, par_calc;

  assign rx_s     = sync2_q;
  assign maj      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign mid      = (cnt_q == CNT_MID);
  assign bit_end  = (cnt_q == CNT_END);
  assign par_calc = (^shreg_q) ^ maj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      s0_q        <= 1'b0;
      s1_q        <= 1'b0;
      shreg_q     <= '0;
      perr_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      rx_prev_q   <= rx_s;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      shreg_q     <= shreg_d;
      perr_pend_q <= perr_pend_d;
      ferr_pend_q <= ferr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = bit_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    s0_d        = (cnt_q == CNT_S0) ? rx_s : s0_q;
    s1_d        = (cnt_q == CNT_S1) ? rx_s : s1_q;
    shreg_d     = shreg_q;
    perr_pend_d = perr_pend_q;
    ferr_pend_d = ferr_pend_q;
    data_d      = data_q;
    valid_d     = valid_q & ~ready_i;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    overrun_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d     = S_START;
          perr_pend_d = 1'b0;
          ferr_pend_d = 1'b0;
        end
      end
      S_START: begin
        if (mid && maj) state_d = S_IDLE;
        else if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        // LSB arrives first, so each new bit enters at the top and walks down
        if (mid) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (idx_q == IDX_LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (mid) perr_pend_d = (PARITY == 1) ? ~par_calc : par_calc;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid) begin
          if (!maj) ferr_pend_d = 1'b1;
          // Leave early on the last stop bit so a following start edge is never missed
          if (idx_q == IDX_LAST_STOP) state_d = S_DONE;
        end
        if (bit_end) idx_d = idx_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        if (!valid_q || ready_i) begin
          data_d  = shreg_q;
          perr_d  = perr_pend_q;
          ferr_d  = ferr_pend_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != S_IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8N1 instance (A) and an 8E1 instance (B),
// directed frames with hand-computed expectations checked by per-channel monitors.
module tb_uart_rx_frame;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic       ready_a = 1'b1, ready_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ov_a_o, ov_b_o, busy_a, busy_b;
  logic [2:0] state_a, state_b;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx_i(rx_a), .data_o(data_a), .valid_o(valid_a), .ready_i(ready_a),
    .parity_err_o(perr_a), .frame_err_o(ferr_a), .overrun_o(ov_a_o), .busy_o(busy_a),
    .state_o(state_a)
  );

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .rx_i(rx_b), .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
    .parity_err_o(perr_b), .frame_err_o(ferr_b), .overrun_o(ov_b_o), .busy_o(busy_b),
    .state_o(state_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         at_cyc;  // negative: arrival cycle not checked
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ov_a    = 0;
  int   ov_b    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] d, input logic pe, input logic fe,
                      input int at);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.at_cyc = at;
    if (ch == 0) q_a.push_back(e);
    else q_b.push_back(e);
  endtask

  // A frame is new when valid is seen and the previous sample was not a held, unaccepted frame
  task automatic monitor(input int ch);
    logic pv = 1'b0, pr = 1'b0;
    logic v, r, pe, fe, ov;
    logic [7:0] d;
    exp_t e;
    bit have;
    forever begin
      @(negedge clk);
      v  = (ch == 0) ? valid_a : valid_b;
      r  = (ch == 0) ? ready_a : ready_b;
      d  = (ch == 0) ? data_a  : data_b;
      pe = (ch == 0) ? perr_a  : perr_b;
      fe = (ch == 0) ? ferr_a  : ferr_b;
      ov = (ch == 0) ? ov_a_o  : ov_b_o;
      if (!rst) begin
        pv = 1'b0; pr = 1'b0;
        continue;
      end
      if (ov) begin
        if (ch == 0) ov_a++;
        else ov_b++;
      end
      if (v && !(pv && !pr)) begin
        n_tests++;
        have = (ch == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
        if (!have) begin
          n_fail++;
          $display("FAIL mon_ch%0d unexpected frame: got data=%02h perr=%0b ferr=%0b, required none",
                   ch, d, pe, fe);
        end else begin
          e = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
          if (d !== e.data || pe !== e.perr || fe !== e.ferr ||
              (e.at_cyc >= 0 && cyc != e.at_cyc)) begin
            n_fail++;
            $display("FAIL mon_ch%0d frame: got data=%02h perr=%0b ferr=%0b cyc=%0d, required data=%02h perr=%0b ferr=%0b cyc=%0d",
                     ch, d, pe, fe, cyc, e.data, e.perr, e.ferr, e.at_cyc);
          end else begin
            $display("[TB] ch%0d frame data=%02h perr=%0b ferr=%0b cyc=%0d ok", ch, d, pe, fe, cyc);
          end
        end
      end
      pv = v; pr = r;
    end
  endtask

  // Each bit is held CPB cycles; bits[0] goes first (start bit)
  task automatic tx(input int ch, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (ch == 0) rx_a = bits[i];
      else rx_b = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c0, ov0;

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none

    // Reset state
    idle(3);
    check("rst_data_a", data_a, 8'h00);
    check("rst_valid_a", valid_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_state_a", state_a, 3'd0);
    check("rst_flags_a", {perr_a, ferr_a, ov_a_o}, 3'b000);
    check("rst_b", {valid_b, busy_b, state_b, perr_b, ferr_b, ov_b_o}, 8'h00);
    rst = 1'b1;
    idle(10);

    // 8N1 0xA5: valid at cycle 155 after START entry (3 cycles after the pin falls)
    c0 = cyc;
    push(0, 8'hA5, 1'b0, 1'b0, c0 + 158);
    tx(0, {1'b1, 8'hA5, 1'b0}, 10);
    idle(20);

    // Stop bit driven low, then line held low
    c0 = cyc;
    push(0, 8'h5A, 1'b0, 1'b1, c0 + 158);
    tx(0, {1'b0, 8'h5A, 1'b0}, 10);
    idle(100);
    check("hold_low_busy", busy_a, 1'b0);
    rx_a = 1'b1;
    idle(20);
    push(0, 8'h3C, 1'b0, 1'b0, -1);
    tx(0, {1'b1, 8'h3C, 1'b0}, 10);
    idle(20);

    // Start glitch: 5 low cycles, abort lands on cycle 10
    c0 = cyc;
    rx_a = 1'b0;
    idle(5);
    rx_a = 1'b1;
    while (cyc < c0 + 12) @(negedge clk);
    check("glitch_busy_c9", busy_a, 1'b1);
    @(negedge clk);
    check("glitch_busy_c10", busy_a, 1'b0);
    @(posedge clk);
    #1;
    idle(40);

    // Overrun: second back-to-back frame is dropped
    ready_a = 1'b0;
    ov0 = ov_a;
    push(0, 8'h11, 1'b0, 1'b0, -1);
    tx(0, {1'b1, 8'h11, 1'b0}, 10);
    tx(0, {1'b1, 8'h22, 1'b0}, 10);
    idle(20);
    check("ovr_data_held", data_a, 8'h11);
    check("ovr_valid_held", valid_a, 1'b1);
    check("ovr_pulses", ov_a - ov0, 1);
    ready_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_clear", valid_a, 1'b0);
    @(posedge clk);
    #1;
    idle(10);

    // Reset in the middle of DATA with a frame held at the output
    ready_a = 1'b0;
    push(0, 8'h44, 1'b0, 1'b0, -1);
    tx(0, {1'b1, 8'h44, 1'b0}, 10);
    idle(10);
    check("pre_rst_valid", valid_a, 1'b1);
    c0 = cyc;
    fork
      tx(0, {1'b1, 8'hC3, 1'b0}, 10);
      begin
        while (cyc < c0 + 63) begin
          @(posedge clk);
          #1;
        end
        check("mid_busy_before_rst", busy_a, 1'b1);
        rst = 1'b0;
        #1;
        check("midrst_data", data_a, 8'h00);
        check("midrst_valid", valid_a, 1'b0);
        check("midrst_busy", busy_a, 1'b0);
        check("midrst_state", state_a, 3'd0);
        check("midrst_flags", {perr_a, ferr_a, ov_a_o}, 3'b000);
      end
    join
    rst = 1'b1;
    ready_a = 1'b1;
    idle(10);
    c0 = cyc;
    push(0, 8'h7E, 1'b0, 1'b0, c0 + 158);
    tx(0, {1'b1, 8'h7E, 1'b0}, 10);
    idle(30);

    // 8E1: 0x03 has even weight, so parity bit 1 is an error and 0 is clean
    c0 = cyc;
    push(1, 8'h03, 1'b1, 1'b0, c0 + 174);
    tx(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    idle(20);
    c0 = cyc;
    push(1, 8'h03, 1'b0, 1'b0, c0 + 174);
    tx(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    idle(30);

    check("q_a_empty", q_a.size(), 0);
    check("q_b_empty", q_b.size(), 0);
    check("ov_b_none", ov_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised RS232 receiver with:
- configurable data width, parity and stop bits;
- 3-sample majority voting at mid-bit;
- start-bit glitch rejection;
- a registered valid/ready output with parity, framing and overrun error reporting.

It sits between the board `rx` pin and the core-side UART register block. It contains its own baud/bit counters, so no external baud-rate or bit-counter helpers are needed.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clk cycles per UART bit; legal ≥ 8. `HALF = CLKS_PER_BIT/2` (integer division).
- `DATA_BITS`, 8: payload bits per frame; legal 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `rx_i` in 1: serial line, asynchronous to `clk`, idle high.
- `data_o` out DATA_BITS: received payload, LSB first on the line.
- `valid_o` out 1: `data_o` and error flags hold a frame.
- `ready_i` in 1: consumer accepts the frame.
- `parity_err_o` out 1: parity mismatch for the held frame; always 0 when PARITY=0.
- `frame_err_o` out 1: a stop bit was sampled 0 for the held frame.
- `overrun_o` out 1: one-cycle pulse when a completed frame was dropped.
- `busy_o` out 1: 1 in any state other than IDLE.
- `state_o` out 3: debug, current state encoding.

## Operation
- **Input sync:** `rx_i` passes through 2 flops, reset to 1, giving `rx_s`. All decisions use `rx_s`.
- **States:**
  - **IDLE:** wait for a falling edge of `rx_s` (previous 1, current 0), then go to START with `cnt = 0`. A line held low never retriggers.
  - **START:** majority over `rx_s` sampled at `cnt` = HALF-1, HALF, HALF+1.
    - Majority 1: glitch; go to IDLE at the next cycle, produce no output.
    - Otherwise: go to DATA when `cnt == CLKS_PER_BIT-1`.
  - **DATA:** same 3-sample majority per bit. The result shifts into the MSB of the shift register, so the LSB arrives first. After DATA_BITS bits, go to PARITY if PARITY≠0, else to STOP.
  - **PARITY:** majority-sample the parity bit.
    - Odd: error if the XOR of data and parity bit is 0.
    - Even: error if that XOR is 1.
  - **STOP:** majority-sample each stop bit; any stop bit sampled 0 sets the frame error.
    - On a non-final stop bit, advance at bit end.
    - On the final stop bit, go to DONE immediately after the HALF+1 sample, without waiting for bit end. This allows back-to-back frames.
  - **DONE:** one cycle. Perform the output load, then go to IDLE.
- **`cnt`:** 0 to CLKS_PER_BIT-1, wraps at bit end. Width is `$clog2(CLKS_PER_BIT)`. The bit index counts 0 to DATA_BITS-1.
- **Output load in DONE:**
  - `valid_o == 0`, or `ready_i == 1` in the same cycle: load `data_o`, `parity_err_o` and `frame_err_o`, and set `valid_o = 1`.
  - `valid_o == 1` and `ready_i == 0`: keep the old frame and pulse `overrun_o` for 1 cycle. The new frame is lost.
- **Handshake:**
  - `valid_o` clears the cycle after `valid_o && ready_i`, unless DONE reloads it in that same cycle.
  - `data_o` and the flags are stable while `valid_o == 1`.
- **Reset** (asynchronous, any time, including mid-frame):
  - State IDLE, counters 0, sync flops 1.
  - `data_o` 0; `valid_o`, `parity_err_o`, `frame_err_o`, `overrun_o` and `busy_o` all 0.
  - The partial frame is discarded.

## Timing
- Cycle 0 is the first cycle in START, with `cnt = 0`.
- The pin-to-`rx_s` delay is 2–3 cycles before cycle 0.
- `FRAME_BITS = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS`.
- DONE occurs at cycle `(FRAME_BITS-1)*CLKS_PER_BIT + HALF + 2`; `valid_o` rises one cycle later.
  - Example, 8N1 with CLKS_PER_BIT=16: DONE at cycle 154, `valid_o` at cycle 155.
- A start-glitch abort returns to IDLE at cycle HALF+2.
- An IDLE→START edge can be accepted the cycle after DONE, so a back-to-back frame is never missed.
- Baud tolerance is inherent to mid-bit sampling, about ±4% for 8N1.

## Test plan
- **8N1 (CLKS_PER_BIT=16):** send 0xA5 with `ready_i=1` → `valid_o` high exactly at cycle 155 for 1 cycle; `data_o = 0xA5`; no errors.
- **PARITY=2 (even):** send 0x03 with parity bit 1 → `parity_err_o = 1`, `data_o = 0x03`. Send the same byte with parity 0 → no error.
- **Stop bit driven 0** (0x5A, 8N1) → `frame_err_o = 1`, `data_o = 0x5A`. Then hold the line low → no new frame until the line goes high and falls again.
- **Start glitch:** `rx_i` low for 5 cycles (CLKS_PER_BIT=16) → `busy_o` drops at cycle 10; no `valid_o`.
- **Overrun:** `ready_i = 0`; send 0x11 then 0x22 back-to-back → `data_o` stays 0x11 and `overrun_o` pulses once. Then assert `ready_i` → `valid_o` clears the next cycle.
- **Reset mid-DATA** (`rst` low at cycle 60 of a frame) → all outputs 0 immediately. A frame after reset release (0x7E) is received correctly.
